// File: rtl/dl_bus_sequencer.sv
// DataLatch sequencer: arbitrates write / read / ALU-load / DMA requesters and
// drives the DataLatch bus-connect and ALU-load controls with registered outputs.
module dl_bus_sequencer #(
  parameter int unsigned RD_WAIT  = 1,
  parameter int unsigned WR_HOLD  = 2,
  parameter bit          DMA_PRIO = 1'b1
) (
  input  logic       CLK,
  input  logic       nRES,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       alu_req,
  input  logic       dma_req,
  input  logic [7:0] dl_in,
  output logic       DL_Control1,
  output logic       DL_Control2,
  output logic       wr_done,
  output logic       rd_done,
  output logic       alu_done,
  output logic [7:0] rd_data,
  output logic       dma_gnt,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LOAD,
    S_WR_BUS,
    S_RD_BUS,
    S_ALU_LOAD,
    S_DMA
  } state_t;

  localparam logic [2:0] WR_LOAD_CNT = 3'(WR_HOLD - 1);
  localparam logic [2:0] RD_LOAD_CNT = 3'(RD_WAIT);

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;

  logic ctl1_next, ctl2_next;
  logic wr_done_next, rd_done_next, alu_done_next;
  logic dma_gnt_next, busy_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (DMA_PRIO && dma_req) begin
          state_next = S_DMA;
        end else if (wr_req) begin
          state_next = S_WR_LOAD;
        end else if (rd_req) begin
          state_next = S_RD_BUS;
          cnt_next   = RD_LOAD_CNT;
        end else if (alu_req) begin
          state_next = S_ALU_LOAD;
        end else if (dma_req) begin
          state_next = S_DMA;
        end
      end
      S_WR_LOAD: begin
        state_next = S_WR_BUS;
        cnt_next   = WR_LOAD_CNT;
      end
      S_WR_BUS, S_RD_BUS: begin
        // Counter stops at zero; the zero cycle is the final bus cycle.
        if (cnt_reg == 3'd0) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      S_ALU_LOAD: state_next = S_IDLE;
      S_DMA: begin
        if (!dma_req) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they register alongside it.
  always_comb begin
    ctl1_next     = !((state_next == S_RD_BUS) || (state_next == S_WR_BUS));
    ctl2_next     = (state_next == S_WR_LOAD) || (state_next == S_ALU_LOAD);
    wr_done_next  = (state_next == S_WR_BUS) && (cnt_next == 3'd0);
    rd_done_next  = (state_next == S_RD_BUS) && (cnt_next == 3'd0);
    alu_done_next = (state_next == S_ALU_LOAD);
    dma_gnt_next  = (state_next == S_DMA);
    busy_next     = (state_next != S_IDLE);
  end

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 3'd0;
      DL_Control1 <= 1'b1;
      DL_Control2 <= 1'b0;
      wr_done     <= 1'b0;
      rd_done     <= 1'b0;
      alu_done    <= 1'b0;
      rd_data     <= 8'h00;
      dma_gnt     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      DL_Control1 <= ctl1_next;
      DL_Control2 <= ctl2_next;
      wr_done     <= wr_done_next;
      rd_done     <= rd_done_next;
      alu_done    <= alu_done_next;
      dma_gnt     <= dma_gnt_next;
      busy        <= busy_next;
      if (rd_done_next) begin
        rd_data <= dl_in;
      end
    end
  end

endmodule

// File: tb/tb_dl_bus_sequencer.sv
// Scoreboard bench for dl_bus_sequencer: instance A (DMA priority, RD_WAIT=1, WR_HOLD=2)
// and instance B (CPU priority, RD_WAIT=0, WR_HOLD=1).
module tb_dl_bus_sequencer;

  logic       CLK  = 1'b0;
  logic       nRES = 1'b0;

  logic       a_wr_req = 1'b0, a_rd_req = 1'b0, a_alu_req = 1'b0, a_dma_req = 1'b0;
  logic [7:0] a_dl_in = 8'h00;
  logic       a_ctl1, a_ctl2, a_wr_done, a_rd_done, a_alu_done, a_dma_gnt, a_busy;
  logic [7:0] a_rd_data;

  logic       b_wr_req = 1'b0, b_rd_req = 1'b0, b_alu_req = 1'b0, b_dma_req = 1'b0;
  logic [7:0] b_dl_in = 8'h00;
  logic       b_ctl1, b_ctl2, b_wr_done, b_rd_done, b_alu_done, b_dma_gnt, b_busy;
  logic [7:0] b_rd_data;

  always #5 CLK = ~CLK;

  dl_bus_sequencer #(.RD_WAIT(1), .WR_HOLD(2), .DMA_PRIO(1'b1)) u_dut_a (
    .CLK(CLK), .nRES(nRES),
    .wr_req(a_wr_req), .rd_req(a_rd_req), .alu_req(a_alu_req), .dma_req(a_dma_req),
    .dl_in(a_dl_in),
    .DL_Control1(a_ctl1), .DL_Control2(a_ctl2),
    .wr_done(a_wr_done), .rd_done(a_rd_done), .alu_done(a_alu_done),
    .rd_data(a_rd_data), .dma_gnt(a_dma_gnt), .busy(a_busy)
  );

  dl_bus_sequencer #(.RD_WAIT(0), .WR_HOLD(1), .DMA_PRIO(1'b0)) u_dut_b (
    .CLK(CLK), .nRES(nRES),
    .wr_req(b_wr_req), .rd_req(b_rd_req), .alu_req(b_alu_req), .dma_req(b_dma_req),
    .dl_in(b_dl_in),
    .DL_Control1(b_ctl1), .DL_Control2(b_ctl2),
    .wr_done(b_wr_done), .rd_done(b_rd_done), .alu_done(b_alu_done),
    .rd_data(b_rd_data), .dma_gnt(b_dma_gnt), .busy(b_busy)
  );

  // Event kinds: 0 write done, 1 read done, 2 ALU done, 3 DMA grant rising.
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  // Flags = {DL_Control1, DL_Control2, busy, dma_gnt, wr_done}.
  typedef struct {
    int         cyc;
    logic [4:0] flags;
    bit         chk_data;
    logic [7:0] data;
  } snap_t;

  ev_t   exp_a_q[$];
  ev_t   exp_b_q[$];
  snap_t snap_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic gnt_a_prev = 1'b0;
  logic gnt_b_prev = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic push_a(input int kind, input logic [7:0] d, input int c);
    ev_t e;
    e.kind = kind; e.data = d; e.cyc = c;
    exp_a_q.push_back(e);
  endtask

  task automatic push_b(input int kind, input logic [7:0] d, input int c);
    ev_t e;
    e.kind = kind; e.data = d; e.cyc = c;
    exp_b_q.push_back(e);
  endtask

  task automatic push_snap(input int c, input logic [4:0] f, input bit chk, input logic [7:0] d);
    snap_t s;
    s.cyc = c; s.flags = f; s.chk_data = chk; s.data = d;
    snap_q.push_back(s);
  endtask

  task automatic check_event(input string tag, input int k, input logic [7:0] got_data,
                             input bit have_exp, input ev_t e);
    n_cmp++;
    if (!have_exp) begin
      n_err++;
      $display("FAIL %s_unexpected: got kind=%0d at cyc %0d, required no event", tag, k, cyc);
    end else if (e.kind != k || (k == 1 && got_data != e.data) || (e.cyc >= 0 && e.cyc != cyc)) begin
      n_err++;
      $display("FAIL %s_event: got kind=%0d data=%02h cyc=%0d, required kind=%0d data=%02h cyc=%0d",
               tag, k, got_data, cyc, e.kind, e.data, e.cyc);
    end else begin
      $display("pass %s_event kind=%0d data=%02h cyc=%0d", tag, k, got_data, cyc);
    end
  endtask

  // Monitor: compares observed events and per-cycle snapshots against the queues.
  always @(negedge CLK) begin
    int    k;
    ev_t   e;
    snap_t s;
    bit    have;
    logic [4:0] got;

    while (snap_q.size() > 0 && snap_q[0].cyc < cyc) begin
      s = snap_q.pop_front();
      n_cmp++; n_err++;
      $display("FAIL snap_missed: snapshot for cyc %0d never compared", s.cyc);
    end
    if (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
      s   = snap_q.pop_front();
      got = {a_ctl1, a_ctl2, a_busy, a_dma_gnt, a_wr_done};
      n_cmp++;
      if (got != s.flags || (s.chk_data && a_rd_data != s.data)) begin
        n_err++;
        $display("FAIL snap_cyc%0d: got flags=%05b rd_data=%02h, required flags=%05b rd_data=%02h",
                 cyc, got, a_rd_data, s.flags, s.data);
      end else begin
        $display("pass snap_cyc%0d flags=%05b rd_data=%02h", cyc, got, a_rd_data);
      end
    end

    n_cmp++;
    if ((!a_ctl1 && a_ctl2) || (a_dma_gnt && !a_ctl1) || (!b_ctl1 && b_ctl2) || (b_dma_gnt && !b_ctl1)) begin
      n_err++;
      $display("FAIL invariant cyc%0d: a ctl1/ctl2/gnt=%b%b%b b=%b%b%b, required no bus/ALU overlap",
               cyc, a_ctl1, a_ctl2, a_dma_gnt, b_ctl1, b_ctl2, b_dma_gnt);
    end

    k = -1;
    if (a_wr_done) k = 0;
    else if (a_rd_done) k = 1;
    else if (a_alu_done) k = 2;
    else if (a_dma_gnt && !gnt_a_prev) k = 3;
    gnt_a_prev <= a_dma_gnt;
    if (k >= 0) begin
      have = (exp_a_q.size() > 0);
      e.kind = -1; e.data = 8'h00; e.cyc = -1;
      if (have) e = exp_a_q.pop_front();
      check_event("a", k, a_rd_data, have, e);
    end

    k = -1;
    if (b_wr_done) k = 0;
    else if (b_rd_done) k = 1;
    else if (b_alu_done) k = 2;
    else if (b_dma_gnt && !gnt_b_prev) k = 3;
    gnt_b_prev <= b_dma_gnt;
    if (k >= 0) begin
      have = (exp_b_q.size() > 0);
      e.kind = -1; e.data = 8'h00; e.cyc = -1;
      if (have) e = exp_b_q.pop_front();
      check_event("b", k, b_rd_data, have, e);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Polls at negedges for a DUT output; an expired budget counts as a failure.
  task automatic wait_for(input int which, input int maxc);
    bit hit = 1'b0;
    for (int i = 0; i < maxc && !hit; i++) begin
      @(negedge CLK);
      case (which)
        0: hit = a_wr_done;
        1: hit = a_rd_done;
        2: hit = a_alu_done;
        3: hit = a_dma_gnt;
        4: hit = b_rd_done;
        5: hit = b_dma_gnt;
        6: hit = b_wr_done;
        default: hit = 1'b0;
      endcase
    end
    if (!hit) begin
      n_cmp++; n_err++;
      $display("FAIL timeout_%0d: no event within %0d cycles, required one", which, maxc);
    end
  endtask

  initial begin
    int e0;

    // Reset state
    push_snap(1, 5'b10000, 1'b1, 8'h00);
    tick(2);
    nRES = 1'b1;
    tick(1);

    // Write, WR_HOLD=2
    e0 = cyc;
    a_wr_req = 1'b1;
    push_a(0, 8'h00, e0 + 3);
    push_snap(e0 + 1, 5'b11100, 1'b0, 8'h00);
    push_snap(e0 + 2, 5'b00100, 1'b0, 8'h00);
    push_snap(e0 + 3, 5'b00101, 1'b0, 8'h00);
    push_snap(e0 + 4, 5'b10000, 1'b0, 8'h00);
    wait_for(0, 10);
    a_wr_req = 1'b0;
    tick(2);

    // Read, RD_WAIT=1; rd_data must hold after dl_in changes
    e0 = cyc;
    a_dl_in = 8'hA5;
    a_rd_req = 1'b1;
    push_a(1, 8'hA5, e0 + 2);
    push_snap(e0 + 1, 5'b00100, 1'b0, 8'h00);
    push_snap(e0 + 2, 5'b00100, 1'b1, 8'hA5);
    push_snap(e0 + 3, 5'b10000, 1'b1, 8'hA5);
    wait_for(1, 10);
    a_rd_req = 1'b0;
    a_dl_in  = 8'h11;
    tick(2);

    // wr, rd, alu together: served in that order with one IDLE cycle between
    e0 = cyc;
    a_dl_in = 8'h3C;
    a_wr_req = 1'b1; a_rd_req = 1'b1; a_alu_req = 1'b1;
    push_a(0, 8'h00, e0 + 3);
    push_a(1, 8'h3C, e0 + 6);
    push_a(2, 8'h00, e0 + 8);
    push_snap(e0 + 4, 5'b10000, 1'b0, 8'h00);
    push_snap(e0 + 7, 5'b10000, 1'b1, 8'h3C);
    push_snap(e0 + 8, 5'b11100, 1'b1, 8'h3C);
    wait_for(0, 10);
    a_wr_req = 1'b0;
    wait_for(1, 10);
    a_rd_req = 1'b0;
    wait_for(2, 10);
    a_alu_req = 1'b0;
    tick(2);

    // DMA request rising during RD_BUS waits for the read to finish
    e0 = cyc;
    a_dl_in = 8'h5A;
    a_rd_req = 1'b1;
    tick(1);
    a_dma_req = 1'b1;
    push_a(1, 8'h5A, e0 + 2);
    push_a(3, 8'h00, e0 + 4);
    push_snap(e0 + 3, 5'b10000, 1'b1, 8'h5A);
    push_snap(e0 + 4, 5'b10110, 1'b0, 8'h00);
    wait_for(1, 10);
    a_rd_req = 1'b0;
    wait_for(3, 10);
    tick(2);
    a_dma_req = 1'b0;
    push_snap(cyc, 5'b10110, 1'b0, 8'h00);
    push_snap(cyc + 1, 5'b10000, 1'b0, 8'h00);
    tick(2);

    // DMA_PRIO=1: DMA beats a simultaneous write
    e0 = cyc;
    a_dma_req = 1'b1; a_wr_req = 1'b1;
    push_a(3, 8'h00, e0 + 1);
    push_a(0, 8'h00, e0 + 6);
    wait_for(3, 10);
    tick(1);
    a_dma_req = 1'b0;
    wait_for(0, 10);
    a_wr_req = 1'b0;
    tick(2);

    // DMA_PRIO=0, RD_WAIT=0: read first, DMA after
    e0 = cyc;
    b_dl_in = 8'hC3;
    b_rd_req = 1'b1; b_dma_req = 1'b1;
    push_b(1, 8'hC3, e0 + 1);
    push_b(3, 8'h00, e0 + 3);
    wait_for(4, 10);
    b_rd_req = 1'b0;
    wait_for(5, 10);
    tick(1);
    b_dma_req = 1'b0;
    tick(2);

    // WR_HOLD=1: single bus cycle carries the done pulse
    e0 = cyc;
    b_wr_req = 1'b1;
    push_b(0, 8'h00, e0 + 2);
    wait_for(6, 10);
    b_wr_req = 1'b0;
    tick(2);

    // Reset asserted during WR_BUS: immediate reset values, no wr_done
    e0 = cyc;
    a_wr_req = 1'b1;
    tick(2);
    nRES = 1'b0;
    a_wr_req = 1'b0;
    push_snap(e0 + 2, 5'b10000, 1'b1, 8'h00);
    push_snap(e0 + 3, 5'b10000, 1'b1, 8'h00);
    tick(2);
    nRES = 1'b1;
    tick(3);

    n_cmp++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0 || snap_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d/%0d/%0d expected items outstanding, required 0/0/0",
               exp_a_q.size(), exp_b_q.size(), snap_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
